// File: rtl/lif_neuron_chain.sv
// Chain of leaky integrate-and-fire neurons: neuron 0 integrates an external current,
// each later neuron receives a fixed synaptic weight when its predecessor spikes.
module lif_neuron_chain #(
    parameter int N_NEURONS  = 4,
    parameter int POT_W      = 8,
    parameter int THRESH     = 200,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 4,
    parameter int WEIGHT     = 220
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [POT_W-1:0]     in_current,
    input  logic                 cnt_clr,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 spike_out,
    output logic [7:0]           spike_count
);

    localparam logic [POT_W-1:0] THRESH_V = POT_W'(THRESH);
    localparam logic [POT_W-1:0] WEIGHT_V = POT_W'(WEIGHT);
    localparam logic [3:0]       REFRAC_V = 4'(REFRAC);

    logic [N_NEURONS-1:0] spk_bus;

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_stage
        logic [POT_W-1:0] v_q, v_d;
        logic [POT_W-1:0] syn_in, leak, v_sat;
        logic [POT_W:0]   v_sum;
        logic [3:0]       rc_q, rc_d;
        logic             spk_q, spk_d;

        // One register stage per synapse: neuron k sees the registered spike of k-1.
        if (k == 0) begin : g_head
            assign syn_in = in_current;
        end else begin : g_link
            assign syn_in = spk_bus[k-1] ? WEIGHT_V : '0;
        end

        always_comb begin
            // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
            v_d   = v_q;
            rc_d  = rc_q;
            spk_d = 1'b0;
            leak  = v_q >> LEAK_SHIFT;
            // Leak never exceeds v, so the extra MSB only ever flags an upward overflow.
            v_sum = {1'b0, v_q} - {1'b0, leak} + {1'b0, syn_in};
            v_sat = v_sum[POT_W] ? '1 : v_sum[POT_W-1:0];
            if (ena) begin
                if (rc_q != 4'd0) begin
                    rc_d = rc_q - 4'd1;
                    v_d  = '0;
                end else if (v_sat >= THRESH_V) begin
                    spk_d = 1'b1;
                    v_d   = '0;
                    rc_d  = REFRAC_V;
                end else begin
                    v_d = v_sat;
                end
            end
        end

        // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= '0;
                rc_q  <= '0;
                spk_q <= 1'b0;
            end else begin
                v_q   <= v_d;
                rc_q  <= rc_d;
                spk_q <= spk_d;
            end
        end

        assign spk_bus[k] = spk_q;
    end

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (ena && spk_bus[N_NEURONS-1] && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign spikes      = spk_bus;
    assign spike_out   = spk_bus[N_NEURONS-1];
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron_chain.sv
// Directed bench for lif_neuron_chain: default chain, saturating/clamping variants
// and a sub-threshold-weight variant, each checked against hand-derived values.
module tb_lif_neuron_chain;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       cnt_clr;
    logic [7:0] in_cur, in_s0, in_s7, in_w;

    logic [3:0] spk_m;
    logic       out_m;
    logic [7:0] cnt_m;
    logic [0:0] spk_s0;
    logic       out_s0;
    logic [7:0] cnt_s0;
    logic [0:0] spk_s7;
    logic       out_s7;
    logic [7:0] cnt_s7;
    logic [1:0] spk_w;
    logic       out_w;
    logic [7:0] cnt_w;

    int total = 0;
    int bad   = 0;

    lif_neuron_chain dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_current(in_cur), .cnt_clr(cnt_clr),
        .spikes(spk_m), .spike_out(out_m), .spike_count(cnt_m)
    );

    // No leak, fires every edge on full-scale input, no refractory period.
    lif_neuron_chain #(.N_NEURONS(1), .THRESH(255), .LEAK_SHIFT(0), .REFRAC(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_current(in_s0), .cnt_clr(cnt_clr),
        .spikes(spk_s0), .spike_out(out_s0), .spike_count(cnt_s0)
    );

    // Tiny leak so that two large inputs overflow POT_W bits.
    lif_neuron_chain #(.N_NEURONS(1), .THRESH(255), .LEAK_SHIFT(7)) dut_s7 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_current(in_s7), .cnt_clr(cnt_clr),
        .spikes(spk_s7), .spike_out(out_s7), .spike_count(cnt_s7)
    );

    lif_neuron_chain #(.N_NEURONS(2), .WEIGHT(120), .REFRAC(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_current(in_w), .cnt_clr(cnt_clr),
        .spikes(spk_w), .spike_out(out_w), .spike_count(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default chain from reset with in_current=64: n0 fires on edge 4 then every 8 edges;
    // neuron k follows k edges later.
    function automatic logic [3:0] exp_spk(input int e);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if ((e - 4 - k) >= 0 && ((e - 4 - k) % 8) == 0) r[k] = 1'b1;
        end
        return r;
    endfunction

    // spike_out is high after edges 7, 15, 23 so the count steps on edges 8, 16, 24.
    function automatic int exp_cnt(input int e);
        int c;
        c = 0;
        if (e >= 8)  c++;
        if (e >= 16) c++;
        if (e >= 24) c++;
        return c;
    endfunction

    initial begin
        logic [7:0] w_in  [1:14];
        logic [1:0] w_exp [1:14];

        rst_n   = 1'b1;
        ena     = 1'b1;
        cnt_clr = 1'b0;
        in_cur  = '0;
        in_s0   = '0;
        in_s7   = '0;
        in_w    = '0;

        // Reset state
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_spikes", 32'(spk_m), 32'd0);
        check("rst_out", 32'(out_m), 32'd0);
        check("rst_cnt", 32'(cnt_m), 32'd0);
        check("rst_s0_cnt", 32'(cnt_s0), 32'd0);

        // Integrate, fire, refractory and chain propagation
        in_cur = 8'd64;
        rst_n  = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            tick();
            check($sformatf("chain_spk_e%0d", e), 32'(spk_m), 32'(exp_spk(e)));
            check($sformatf("chain_cnt_e%0d", e), 32'(cnt_m), 32'(exp_cnt(e)));
        end
        // v: 64, 120, 169 after edges 25..27
        check("v_before_freeze", 32'(dut.g_stage[0].v_q), 32'd169);

        // Freeze with ena low
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("freeze_spk_%0d", i), 32'(spk_m), 32'd0);
            check($sformatf("freeze_cnt_%0d", i), 32'(cnt_m), 32'd3);
        end
        check("v_held", 32'(dut.g_stage[0].v_q), 32'd169);
        ena = 1'b1;
        tick();
        check("reena_n0", 32'(spk_m), 32'b0001);   // 169 - 21 + 64 = 212
        tick();
        check("reena_n1", 32'(spk_m), 32'b0010);
        tick();
        check("reena_n2", 32'(spk_m), 32'b0100);
        tick();
        check("reena_n3", 32'(spk_m), 32'b1000);
        check("reena_out", 32'(out_m), 32'd1);
        check("reena_cnt", 32'(cnt_m), 32'd3);

        // Async reset while n3 spikes and n0 is refractory
        rst_n = 1'b0;
        #2;
        check("async_rst_spk", 32'(spk_m), 32'd0);
        check("async_rst_out", 32'(out_m), 32'd0);
        check("async_rst_cnt", 32'(cnt_m), 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            check($sformatf("rerun_spk_e%0d", e), 32'(spk_m), 32'(exp_spk(e)));
            check($sformatf("rerun_cnt_e%0d", e), 32'(cnt_m), 32'(exp_cnt(e)));
        end
        // spike_out is high now; clear wins over the increment
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_vs_spike", 32'(cnt_m), 32'd0);
        for (int e = 17; e <= 24; e++) begin
            tick();
            check($sformatf("postclr_cnt_e%0d", e), 32'(cnt_m), (e >= 24) ? 32'd1 : 32'd0);
        end
        // Clear honoured with ena low
        ena     = 1'b0;
        cnt_clr = 1'b1;
        tick();
        check("clr_ena_low", 32'(cnt_m), 32'd0);
        ena     = 1'b1;
        cnt_clr = 1'b0;

        // Saturation, clamping and first-edge fire
        rst_n  = 1'b0;
        #2;
        in_cur = '0;
        in_s0  = 8'd255;
        in_s7  = 8'd200;
        rst_n  = 1'b1;
        for (int e = 1; e <= 300; e++) begin
            tick();
            check($sformatf("s0_spk_e%0d", e), 32'(spk_s0), 32'd1);
            check($sformatf("s0_out_e%0d", e), 32'(out_s0), 32'd1);
            check($sformatf("s0_cnt_e%0d", e), 32'(cnt_s0), (e - 1 > 255) ? 32'd255 : 32'(e - 1));
            if (e == 1) begin
                check("s7_no_fire_200", 32'(spk_s7), 32'd0);
            end else if (e == 2) begin
                // 200 - 1 + 200 = 399 clamps to 255, reaching THRESH
                check("s7_clamp_fire", 32'(spk_s7), 32'd1);
                check("s7_clamp_out", 32'(out_s7), 32'd1);
                in_s7 = '0;
            end
        end
        check("s7_cnt", 32'(cnt_s7), 32'd1);

        // Sub-threshold weight: n0 spikes 3 edges apart make n1 fire, 4 apart do not
        rst_n = 1'b0;
        #2;
        in_s0 = '0;
        for (int e = 1; e <= 14; e++) begin
            w_in[e]  = '0;
            w_exp[e] = 2'b00;
        end
        w_in[1]  = 8'd255;  w_exp[1]  = 2'b01;
        w_in[4]  = 8'd255;  w_exp[4]  = 2'b01;
        w_exp[5] = 2'b10;   // n1: 120,105,92 then 92-11+120 = 201
        w_in[6]  = 8'd255;  w_exp[6]  = 2'b01;
        w_in[10] = 8'd255;  w_exp[10] = 2'b01;
        rst_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            in_w = w_in[e];
            tick();
            check($sformatf("w_spk_e%0d", e), 32'(spk_w), 32'(w_exp[e]));
            if (e == 5) check("w_out_fire", 32'(out_w), 32'd1);
            // n1: 120,105,92,81 then 81-10+120 = 191, below threshold
            if (e == 11) check("w_v_subthresh", 32'(dut_w.g_stage[1].v_q), 32'd191);
        end
        check("w_cnt", 32'(cnt_w), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
